machine_counters_rv32: RTL and testbench

- Consumer end of the mcountinhibit setup block.
- Holds the 64-bit mcycle and minstret counters and advances them each cycle unless the corresponding inhibit bit is set.
- Provides CSR write access to the machine counters.
- Provides registered CSR read access to both the machine aliases and the user read-only aliases.
- Sits in the CSR file next to the counter-setup register; its read data is muxed into the CSR read path.

---
 rtl/machine_counters_rv32.sv | 152 +++++++++++++++
 tb/tb_machine_counters_rv32.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/machine_counters_rv32.sv
// machine_counters_rv32
// 64-bit mcycle / minstret machine counters with CSR write access and a
// registered CSR read port covering both the machine addresses and the
// user read-only aliases. Counting is gated by the mcountinhibit bits
// supplied by the neighbouring counter-setup register.

module machine_counters_rv32 (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        mcountinhibit_cy_in,
   input  logic        mcountinhibit_ir_in,
   input  logic        instret_inc_in,
   input  logic [11:0] csr_addr_in,
   input  logic        wr_en_in,
   input  logic        rd_en_in,
   input  logic [31:0] data_wr_in,
   output logic [31:0] csr_data_out,
   output logic        rd_valid_out,
   output logic        illegal_out,
   output logic [63:0] mcycle_out,
   output logic [63:0] minstret_out
);

   localparam logic [11:0] MCYCLE    = 12'hB00;
   localparam logic [11:0] MINSTRET  = 12'hB02;
   localparam logic [11:0] MCYCLEH   = 12'hB80;
   localparam logic [11:0] MINSTRETH = 12'hB82;
   localparam logic [11:0] CYCLE     = 12'hC00;
   localparam logic [11:0] INSTRET   = 12'hC02;
   localparam logic [11:0] CYCLEH    = 12'hC80;
   localparam logic [11:0] INSTRETH  = 12'hC82;

   logic [63:0] mcycle_r;
   logic [63:0] minstret_r;
   logic [31:0] csr_data_r;
   logic        rd_valid_r;
   logic        illegal_r;

   logic [63:0] mcycle_nxt_s;
   logic [63:0] minstret_nxt_s;
   logic [31:0] rd_sel_s;
   logic        rd_mapped_s;
   logic        wr_legal_s;
   logic        wr_mcycle_s;
   logic        wr_mcycleh_s;
   logic        wr_minstret_s;
   logic        wr_minstreth_s;

   // Decode the address: read mux source (pre-update counter values) and write targets.
   always_comb begin
      rd_sel_s       = 32'h0000_0000;
      rd_mapped_s    = 1'b1;
      wr_legal_s     = 1'b0;
      wr_mcycle_s    = 1'b0;
      wr_mcycleh_s   = 1'b0;
      wr_minstret_s  = 1'b0;
      wr_minstreth_s = 1'b0;
      case (csr_addr_in)
         MCYCLE: begin
            rd_sel_s    = mcycle_r[31:0];
            wr_legal_s  = 1'b1;
            wr_mcycle_s = wr_en_in;
         end
         MCYCLEH: begin
            rd_sel_s     = mcycle_r[63:32];
            wr_legal_s   = 1'b1;
            wr_mcycleh_s = wr_en_in;
         end
         MINSTRET: begin
            rd_sel_s      = minstret_r[31:0];
            wr_legal_s    = 1'b1;
            wr_minstret_s = wr_en_in;
         end
         MINSTRETH: begin
            rd_sel_s       = minstret_r[63:32];
            wr_legal_s     = 1'b1;
            wr_minstreth_s = wr_en_in;
         end
         CYCLE:    rd_sel_s = mcycle_r[31:0];
         CYCLEH:   rd_sel_s = mcycle_r[63:32];
         INSTRET:  rd_sel_s = minstret_r[31:0];
         INSTRETH: rd_sel_s = minstret_r[63:32];
         default: begin
            rd_sel_s    = 32'h0000_0000;
            rd_mapped_s = 1'b0;
         end
      endcase
   end

   // Next mcycle value: a CSR write to either half beats the increment, no carry from a suppressed increment.
   always_comb begin
      mcycle_nxt_s = mcycle_r;
      if (wr_mcycle_s) begin
         mcycle_nxt_s = {mcycle_r[63:32], data_wr_in};
      end else if (wr_mcycleh_s) begin
         mcycle_nxt_s = {data_wr_in, mcycle_r[31:0]};
      end else if (!mcountinhibit_cy_in) begin
         mcycle_nxt_s = mcycle_r + 64'd1;
      end else begin
         mcycle_nxt_s = mcycle_r;
      end
   end

   // Next minstret value: same precedence, increment only on a retire pulse while not inhibited.
   always_comb begin
      minstret_nxt_s = minstret_r;
      if (wr_minstret_s) begin
         minstret_nxt_s = {minstret_r[63:32], data_wr_in};
      end else if (wr_minstreth_s) begin
         minstret_nxt_s = {data_wr_in, minstret_r[31:0]};
      end else if (instret_inc_in && !mcountinhibit_ir_in) begin
         minstret_nxt_s = minstret_r + 64'd1;
      end else begin
         minstret_nxt_s = minstret_r;
      end
   end

   // Counter state registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mcycle_r   <= 64'd0;
         minstret_r <= 64'd0;
      end else begin
         mcycle_r   <= mcycle_nxt_s;
         minstret_r <= minstret_nxt_s;
      end
   end

   // Registered read data, read-valid pulse and illegal-access flag.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         csr_data_r <= 32'h0000_0000;
         rd_valid_r <= 1'b0;
         illegal_r  <= 1'b0;
      end else begin
         rd_valid_r <= rd_en_in;
         illegal_r  <= (rd_en_in && !rd_mapped_s) || (wr_en_in && !wr_legal_s);
         if (rd_en_in) begin
            csr_data_r <= rd_sel_s;
         end else begin
            csr_data_r <= csr_data_r;
         end
      end
   end

   assign csr_data_out = csr_data_r;
   assign rd_valid_out = rd_valid_r;
   assign illegal_out  = illegal_r;
   assign mcycle_out   = mcycle_r;
   assign minstret_out = minstret_r;

endmodule

// File: tb/tb_machine_counters_rv32.sv
// Directed self-checking bench for machine_counters_rv32.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_machine_counters_rv32;

   logic        clk_in;
   logic        rst_in;
   logic        mcountinhibit_cy_in;
   logic        mcountinhibit_ir_in;
   logic        instret_inc_in;
   logic [11:0] csr_addr_in;
   logic        wr_en_in;
   logic        rd_en_in;
   logic [31:0] data_wr_in;
   logic [31:0] csr_data_out;
   logic        rd_valid_out;
   logic        illegal_out;
   logic [63:0] mcycle_out;
   logic [63:0] minstret_out;

   int total_cnt;
   int bad_cnt;

   machine_counters_rv32 dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .mcountinhibit_cy_in (mcountinhibit_cy_in),
      .mcountinhibit_ir_in (mcountinhibit_ir_in),
      .instret_inc_in      (instret_inc_in),
      .csr_addr_in         (csr_addr_in),
      .wr_en_in            (wr_en_in),
      .rd_en_in            (rd_en_in),
      .data_wr_in          (data_wr_in),
      .csr_data_out        (csr_data_out),
      .rd_valid_out        (rd_valid_out),
      .illegal_out         (illegal_out),
      .mcycle_out          (mcycle_out),
      .minstret_out        (minstret_out)
   );

   // 10-unit clock.
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt = total_cnt + 1;
      if (obs !== exp) begin
         bad_cnt = bad_cnt + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_bus();
      wr_en_in    = 1'b0;
      rd_en_in    = 1'b0;
      csr_addr_in = 12'h000;
      data_wr_in  = 32'h0000_0000;
   endtask

   logic [4:0] inc_pat;

   initial begin
      total_cnt           = 0;
      bad_cnt             = 0;
      rst_in              = 1'b0;
      mcountinhibit_cy_in = 1'b0;
      mcountinhibit_ir_in = 1'b0;
      instret_inc_in      = 1'b0;
      idle_bus();

      // Reset state
      #12;
      chk("rst_mcycle",   mcycle_out,   64'd0);
      chk("rst_minstret", minstret_out, 64'd0);
      chk("rst_data",     {32'd0, csr_data_out}, 64'd0);
      chk("rst_valid",    {63'd0, rd_valid_out}, 64'd0);
      chk("rst_illegal",  {63'd0, illegal_out},  64'd0);

      // Release reset between edges, count 10 edges
      #4 rst_in = 1'b1;
      @(negedge clk_in);
      for (int i = 0; i < 10; i++) step();
      chk("cnt10", mcycle_out, 64'd10);

      // Read MCYCLE: returns pre-edge value 10
      csr_addr_in = 12'hB00; rd_en_in = 1'b1;
      step();
      idle_bus();
      chk("rd_mcycle_data",  {32'd0, csr_data_out}, 64'd10);
      chk("rd_mcycle_valid", {63'd0, rd_valid_out}, 64'd1);
      chk("rd_mcycle_ill",   {63'd0, illegal_out},  64'd0);
      chk("mcycle_11",       mcycle_out, 64'd11);
      step();
      chk("valid_drop", {63'd0, rd_valid_out}, 64'd0);
      chk("data_hold",  {32'd0, csr_data_out}, 64'd10);
      chk("minstret_idle", minstret_out, 64'd0);

      // Low-half carry into high half
      csr_addr_in = 12'hB00; wr_en_in = 1'b1; data_wr_in = 32'hFFFF_FFFE;
      step();
      csr_addr_in = 12'hB80; data_wr_in = 32'h0000_0000;
      step();
      chk("wr_no_inc", mcycle_out, 64'h0000_0000_FFFF_FFFE);
      idle_bus();
      for (int i = 0; i < 3; i++) step();
      chk("carry", mcycle_out, 64'h0000_0001_0000_0001);
      csr_addr_in = 12'hC80; rd_en_in = 1'b1;
      step();
      idle_bus();
      chk("rd_cycleh", {32'd0, csr_data_out}, 64'd1);
      chk("mcycle_after_rd", mcycle_out, 64'h0000_0001_0000_0002);

      // Cycle inhibit with instret pulses 1,0,1,1,0
      mcountinhibit_cy_in = 1'b1;
      inc_pat = 5'b01101;
      for (int i = 0; i < 5; i++) begin
         instret_inc_in = inc_pat[i];
         step();
      end
      chk("cy_frozen",  mcycle_out,   64'h0000_0001_0000_0002);
      chk("ir_counted", minstret_out, 64'd3);
      mcountinhibit_ir_in = 1'b1;
      instret_inc_in      = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("ir_frozen", minstret_out, 64'd3);

      // Write beats increment
      mcountinhibit_ir_in = 1'b0;
      csr_addr_in = 12'hB02; wr_en_in = 1'b1; data_wr_in = 32'h0000_1234;
      step();
      idle_bus();
      instret_inc_in = 1'b0;
      chk("wr_beats_inc", minstret_out, 64'h0000_0000_0000_1234);

      // Simultaneous read and write to MINSTRETH
      csr_addr_in = 12'hB82; wr_en_in = 1'b1; rd_en_in = 1'b1; data_wr_in = 32'h0000_0005;
      step();
      idle_bus();
      chk("rdwr_pre",   {32'd0, csr_data_out}, 64'd0);
      chk("rdwr_state", minstret_out, 64'h0000_0005_0000_1234);
      csr_addr_in = 12'hC02; rd_en_in = 1'b1;
      step();
      idle_bus();
      chk("rd_instret", {32'd0, csr_data_out}, 64'h1234);

      // Write to user alias is illegal and ignored (cycle still inhibited)
      csr_addr_in = 12'hC00; wr_en_in = 1'b1; data_wr_in = 32'h0000_DEAD;
      step();
      idle_bus();
      chk("alias_wr_ill",   {63'd0, illegal_out}, 64'd1);
      chk("alias_wr_state", mcycle_out, 64'h0000_0001_0000_0002);
      step();
      chk("ill_drop", {63'd0, illegal_out}, 64'd0);

      // Unmapped read
      csr_addr_in = 12'h7FF; rd_en_in = 1'b1;
      step();
      idle_bus();
      chk("unmap_data",  {32'd0, csr_data_out}, 64'd0);
      chk("unmap_ill",   {63'd0, illegal_out},  64'd1);
      chk("unmap_valid", {63'd0, rd_valid_out}, 64'd1);

      // 64-bit wrap
      mcountinhibit_cy_in = 1'b0;
      csr_addr_in = 12'hB00; wr_en_in = 1'b1; data_wr_in = 32'hFFFF_FFFF;
      step();
      csr_addr_in = 12'hB80;
      step();
      idle_bus();
      chk("all_ones", mcycle_out, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      chk("wrap", mcycle_out, 64'd0);

      // Asynchronous reset mid-operation with a pending read-valid
      step();
      step();
      csr_addr_in = 12'hB00; rd_en_in = 1'b1;
      step();
      chk("pre_rst_data", {32'd0, csr_data_out}, 64'd2);
      #2 rst_in = 1'b0;
      #1;
      chk("arst_mcycle",   mcycle_out,   64'd0);
      chk("arst_minstret", minstret_out, 64'd0);
      chk("arst_data",     {32'd0, csr_data_out}, 64'd0);
      chk("arst_valid",    {63'd0, rd_valid_out}, 64'd0);
      idle_bus();
      step();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
